// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, 3-sample majority vote at mid-bit,
// a show-ahead RX FIFO and sticky framing/parity/overrun flags.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data,
    output logic                 available,
    input  logic                 rd_en,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clear_err
);
    localparam int CYCLE  = CLK_FREQ / BAUD_RATE;
    localparam int HALF   = CYCLE / 2;
    localparam int CNT_W  = $clog2(CYCLE + 1);
    localparam int IDX_W  = 4;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  SAMP_A    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  SAMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]  SAMP_C    = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CYCLE - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic ones;
        ones = ^{d, p};
        return (PARITY == 1) ? ~ones : ones;
    endfunction

    logic                 sync1, sync2, rx_prev, primed;
    logic [1:0]           warm;
    logic                 rx_s, fall, vote, mid_last, bit_end;
    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic                 shift_en, fe_set, pe_set, push_set, push_p0;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shift_data;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]    fcount;
    logic                 pop, full, wr_ok, ov_set;

    // Synchroniser; 'primed' blocks start detection until the line is seen
    // idle-high after reset, so a reset released mid-frame cannot fake a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            warm    <= '0;
            primed  <= 1'b0;
        end else begin
            sync1   <= rx_pin;
            sync2   <= sync1;
            rx_prev <= sync2;
            warm    <= {warm[0], 1'b1};
            primed  <= primed | (warm[1] & sync2);
        end
    end

    assign rx_s     = sync2;
    assign fall     = primed & rx_prev & ~rx_s;
    assign mid_last = (cnt == SAMP_C);
    assign bit_end  = (cnt == BIT_END);
    assign vote     = majority(s0, s1, rx_s);

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + 1'b1;
        idx_d    = idx;
        shift_en = 1'b0;
        fe_set   = 1'b0;
        pe_set   = 1'b0;
        push_set = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (mid_last && vote) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                shift_en = mid_last;
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                pe_set = mid_last & parity_bad(shift_data, vote);
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                if (mid_last) begin
                    if (!vote) begin
                        fe_set  = 1'b1;
                        state_d = S_BREAK;
                        cnt_d   = '0;
                    end else if (idx == LAST_STOP) begin
                        push_set = 1'b1;
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                    end
                end else if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            push_p0 <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            push_p0 <= push_set;
        end
    end

    // Datapath: vote samples, deserialiser and FIFO storage (no reset needed)
    always_ff @(posedge clk) begin
        if (cnt == SAMP_A) s0 <= rx_s;
        if (cnt == SAMP_B) s1 <= rx_s;
        if (shift_en) shift_data <= {vote, shift_data[DATA_BITS-1:1]};
        if (wr_ok) mem[wr_ptr] <= shift_data;
    end

    assign available = (fcount != '0);
    assign pop       = rd_en & available;
    assign full      = (fcount == FULL_CNT);
    assign wr_ok     = push_p0 & (~full | pop);
    assign ov_set    = push_p0 & full & ~pop;
    assign data      = available ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: fcount <= fcount;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clear_err wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= fe_set | (frame_err & ~clear_err);
            parity_err <= pe_set | (parity_err & ~clear_err);
            overrun    <= ov_set | (overrun & ~clear_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 and an 8E1 instance, 16 clocks per bit.
module tb_uart_rx_fifo;
    localparam int CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rd0, clr0, avail0, fe0, pe0, ov0;
    logic       rx1, rd1, clr1, avail1, fe1, pe1, ov1;
    logic [7:0] data0, data1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx0), .data(data0), .available(avail0),
        .rd_en(rd0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .clear_err(clr0)
    );

    uart_rx_fifo #(
        .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8e1 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx1), .data(data1), .available(avail1),
        .rd_en(rd1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .clear_err(clr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input int ch, input logic v, input int n);
        if (ch == 0) rx0 = v;
        else rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    // par < 0: no parity bit; gbit >= 0: one-clock inverted glitch at mid-bit of that data bit
    task automatic send(input int ch, input logic [7:0] d, input int par, input logic stop,
                        input int gbit);
        line(ch, 1'b0, CYC);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                line(ch, d[i], 8);
                line(ch, ~d[i], 1);
                line(ch, d[i], CYC - 9);
            end else begin
                line(ch, d[i], CYC);
            end
        end
        if (par >= 0) line(ch, par[0], CYC);
        line(ch, stop, CYC);
    endtask

    task automatic pop0();
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
    endtask

    task automatic clear0();
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rx0 = 1'b1; rd0 = 1'b0; clr0 = 1'b0;
        rx1 = 1'b1; rd1 = 1'b0; clr1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_avail", avail0, 1'b0);
        check("rst_data", data0, 8'h00);
        check("rst_flags", {fe0, pe0, ov0}, 3'b000);
        check("rst_avail_e", avail1, 1'b0);
        rst_n = 1'b1;
        line(0, 1'b1, CYC);

        // 8N1 basic frame
        send(0, 8'h41, -1, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("t1_avail", avail0, 1'b1);
        check("t1_data", data0, 8'h41);
        check("t1_flags", {fe0, pe0, ov0}, 3'b000);
        pop0();
        check("t1_pop", avail0, 1'b0);

        // Even parity, wrong parity bit: data still pushed
        send(1, 8'h41, 1, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("t2_avail", avail1, 1'b1);
        check("t2_data", data1, 8'h41);
        check("t2_perr", pe1, 1'b1);
        check("t2_ferr", fe1, 1'b0);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        check("t2_clear", pe1, 1'b0);
        check("t2_keep", avail1, 1'b1);

        // Framing error, break, then recovery
        send(0, 8'h7E, -1, 1'b0, -1);
        check("t3_ferr", fe0, 1'b1);
        check("t3_noavail", avail0, 1'b0);
        line(0, 1'b0, CYC);
        line(0, 1'b1, CYC);
        send(0, 8'h55, -1, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("t3_avail", avail0, 1'b1);
        check("t3_data", data0, 8'h55);
        pop0();
        clear0();
        check("t3_clear", fe0, 1'b0);

        // Overrun: five frames into a four-deep FIFO
        for (int k = 1; k <= 5; k++) send(0, k[7:0], -1, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("t4_ovr", ov0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            check("t4_avail", avail0, 1'b1);
            check("t4_data", data0, k);
            pop0();
        end
        check("t4_empty", avail0, 1'b0);
        pop0();
        check("t4_empty_pop", avail0, 1'b0);

        // False start and a single-clock glitch on a data bit
        clear0();
        check("t5_clear", ov0, 1'b0);
        line(0, 1'b0, CYC / 4);
        line(0, 1'b1, 2 * CYC);
        check("t5_nopush", avail0, 1'b0);
        check("t5_noflags", {fe0, pe0, ov0}, 3'b000);
        send(0, 8'hA5, -1, 1'b1, 0);
        repeat (2) @(negedge clk);
        check("t5_avail", avail0, 1'b1);
        check("t5_data", data0, 8'hA5);

        // Reset during data bit 3 of 0x81
        line(0, 1'b0, CYC);
        line(0, 1'b1, CYC);
        line(0, 1'b0, 2 * CYC);
        line(0, 1'b0, 8);
        rst_n = 1'b0;
        #1;
        check("t6_avail", avail0, 1'b0);
        check("t6_data", data0, 8'h00);
        check("t6_flags", {fe0, pe0, ov0}, 3'b000);
        check("t6_avail_e", avail1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        line(0, 1'b0, CYC - 8 - 3);
        line(0, 1'b0, 3 * CYC);
        line(0, 1'b1, 3 * CYC);
        check("t6_nopartial", avail0, 1'b0);
        send(0, 8'h3C, -1, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("t6_avail2", avail0, 1'b1);
        check("t6_data2", data0, 8'h3C);
        check("t6_flags2", {fe0, pe0, ov0}, 3'b000);
        pop0();
        check("t6_single", avail0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
